// File: rtl/aes_inv_mixcol_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_inv_mixcol_seq_pkg                                         |
// | Purpose  : Shared definitions for the column-serial AES inverse round     |
// |            tail: geometry constants, FSM encoding and GF(2^8) helpers.    |
// |            The GF helpers are shared with the forward MixColumns path.    |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package aes_inv_mixcol_seq_pkg;

   // AES-128 geometry. These values are fixed and must not be changed.
   localparam int NCOL = 4;
   localparam int COLW = 32;

   // Low byte of the reduction polynomial x^8 + x^4 + x^3 + x + 1 (0x11b).
   localparam logic [7:0] AES_POLY = 8'h1b;

   // Code 2'd3 is unused; the FSM sends it back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Multiply by x, reducing modulo the AES polynomial.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   // The constant multiplies below use only the xtime chain x2, x4, x8.
   function automatic logic [7:0] gf_mul09(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = gf_xtime(a);
      x4 = gf_xtime(x2);
      x8 = gf_xtime(x4);
      return x8 ^ a;
   endfunction

   function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = gf_xtime(a);
      x4 = gf_xtime(x2);
      x8 = gf_xtime(x4);
      return x8 ^ x2 ^ a;
   endfunction

   function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = gf_xtime(a);
      x4 = gf_xtime(x2);
      x8 = gf_xtime(x4);
      return x8 ^ x4 ^ a;
   endfunction

   function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = gf_xtime(a);
      x4 = gf_xtime(x2);
      x8 = gf_xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_mixcol_seq_mix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_inv_mix_column                                             |
// | Purpose  : Combinational InvMixColumns for one 32-bit AES column.         |
// |            Row 0 sits in the MSB byte.                                    |
// | Ports    : i_Col [31:0]  input column                                     |
// |            o_Col [31:0]  transformed column                               |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module aes_inv_mix_column
   import aes_inv_mixcol_seq_pkg::*;
(
   input  logic [COLW-1:0] i_Col,
   output logic [COLW-1:0] o_Col
);

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] r0, r1, r2, r3;

   always_comb begin
      a0 = i_Col[31:24];
      a1 = i_Col[23:16];
      a2 = i_Col[15:8];
      a3 = i_Col[7:0];
      // r_i = 0e*a_i ^ 0b*a_(i+1) ^ 0d*a_(i+2) ^ 09*a_(i+3)
      r0 = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
      r1 = gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3) ^ gf_mul09(a0);
      r2 = gf_mul0e(a2) ^ gf_mul0b(a3) ^ gf_mul0d(a0) ^ gf_mul09(a1);
      r3 = gf_mul0e(a3) ^ gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2);
      o_Col = {r0, r1, r2, r3};
   end

endmodule
`default_nettype wire

// File: rtl/aes_inv_mixcol_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_inv_mixcol_seq                                             |
// | Purpose  : Column-serial AES-128 decryption round tail: AddRoundKey then  |
// |            InvMixColumns (skipped when bypassed, for the last round).     |
// |            One column per clock through a single shared column unit.      |
// | Ports    : i_Clk        clock, rising edge                                |
// |            i_Rstn       synchronous active-low reset                      |
// |            i_Valid      input state/key valid                             |
// |            o_Ready      block can accept (IDLE only)                      |
// |            i_State      128-bit state, column c = [127-32c -: 32]         |
// |            i_RoundKey   128-bit round key, same layout                    |
// |            i_Bypass     1: output is State ^ Key only                     |
// |            o_Valid      result valid, held until accepted                 |
// |            i_Ready      downstream accepts o_State                        |
// |            o_State      registered 128-bit result                         |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module aes_inv_mixcol_seq
   import aes_inv_mixcol_seq_pkg::*;
(
   input  logic                 i_Clk,
   input  logic                 i_Rstn,
   input  logic                 i_Valid,
   output logic                 o_Ready,
   input  logic [NCOL*COLW-1:0] i_State,
   input  logic [NCOL*COLW-1:0] i_RoundKey,
   input  logic                 i_Bypass,
   output logic                 o_Valid,
   input  logic                 i_Ready,
   output logic [NCOL*COLW-1:0] o_State
);

   state_t              state, next_state;
   logic [1:0]          col_cnt;
   logic                bypass_q;
   logic [COLW-1:0]     st_q   [NCOL];
   logic [COLW-1:0]     key_q  [NCOL];
   logic [COLW-1:0]     res_q  [NCOL];

   logic [COLW-1:0]     col_in;
   logic [COLW-1:0]     col_mixed;
   logic [COLW-1:0]     col_new;
   logic [NCOL*COLW-1:0] res_full;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_Clk) begin
      if (!i_Rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      o_Ready    = 1'b0;
      o_Valid    = 1'b0;
      case (state)
         ST_IDLE: begin
            o_Ready = 1'b1;
            if (i_Valid) next_state = ST_BUSY;
         end
         ST_BUSY: begin
            if (col_cnt == 2'd3) next_state = ST_DONE;
         end
         ST_DONE: begin
            o_Valid = 1'b1;
            if (i_Ready) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------ column mux and unit
   assign col_in = st_q[col_cnt] ^ key_q[col_cnt];

   aes_inv_mix_column u_mix (
      .i_Col (col_in),
      .o_Col (col_mixed)
   );

   assign col_new = bypass_q ? col_in : col_mixed;

   // Full result as it will look after this cycle's column is written;
   // used to load o_State on the last column so it never shows partials.
   always_comb begin
      res_full = '0;
      for (int c = 0; c < NCOL; c++) begin
         res_full[(NCOL-1-c)*COLW +: COLW] =
            (col_cnt == c[1:0]) ? col_new : res_q[c];
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge i_Clk) begin
      if (!i_Rstn) begin
         col_cnt  <= 2'd0;
         bypass_q <= 1'b0;
         o_State  <= '0;
         for (int c = 0; c < NCOL; c++) begin
            st_q[c]  <= '0;
            key_q[c] <= '0;
            res_q[c] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_Valid) begin
                  col_cnt  <= 2'd0;
                  bypass_q <= i_Bypass;
                  for (int c = 0; c < NCOL; c++) begin
                     st_q[c]  <= i_State[(NCOL-1-c)*COLW +: COLW];
                     key_q[c] <= i_RoundKey[(NCOL-1-c)*COLW +: COLW];
                  end
               end
            end
            ST_BUSY: begin
               res_q[col_cnt] <= col_new;
               // 2-bit counter wraps 3->0 on the same edge as BUSY->DONE.
               col_cnt        <= col_cnt + 2'd1;
               if (col_cnt == 2'd3) o_State <= res_full;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_mixcol_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_inv_mixcol_seq                                          |
// | Purpose  : Self-checking bench for aes_inv_mixcol_seq: known vectors,     |
// |            latency, backpressure, reset abort, throughput and a random   |
// |            handshake run against a generic GF(2^8) reference model.      |
// | Ports    : none                                                           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_aes_inv_mixcol_seq;

   logic         clk = 1'b0;
   logic         rstn;
   logic         in_valid;
   logic         out_ready_dut;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic         in_bypass;
   logic         out_valid;
   logic         in_ready;
   logic [127:0] out_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   aes_inv_mixcol_seq dut (
      .i_Clk      (clk),
      .i_Rstn     (rstn),
      .i_Valid    (in_valid),
      .o_Ready    (out_ready_dut),
      .i_State    (in_state),
      .i_RoundKey (in_key),
      .i_Bypass   (in_bypass),
      .o_Valid    (out_valid),
      .i_Ready    (in_ready),
      .o_State    (out_state)
   );

   // ------------------------------------------------- reference model
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int x, r;
      x = int'(a);
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = x << 1;
         if ((x & 'h100) != 0) x = x ^ 'h11b;
      end
      return r[7:0];
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] coef [4];
      logic [7:0] r;
      logic [31:0] o;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      o = '0;
      for (int i = 0; i < 4; i++) begin
         r = 8'h00;
         for (int j = 0; j < 4; j++) r = r ^ gmul(coef[j], a[(i+j)%4]);
         o[31-8*i -: 8] = r;
      end
      return o;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                          input logic b);
      logic [127:0] o;
      logic [31:0]  t;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         t = s[127-32*c -: 32] ^ k[127-32*c -: 32];
         o[127-32*c -: 32] = b ? t : inv_col(t);
      end
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ------------------------------------------------------- checkers
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // All stimulus steps happen 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a block, wait for accept, then wait for o_Valid (left in DONE).
   task automatic start_block(input logic [127:0] s, input logic [127:0] k,
                              input logic b, output int lat);
      int n;
      in_state = s; in_key = k; in_bypass = b; in_valid = 1'b1;
      n = 0;
      while (!out_ready_dut && n < 20) begin step(); n++; end
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      lat = n;
   endtask

   task automatic accept_out();
      in_ready = 1'b1;
      step();
      in_ready = 1'b0;
   endtask

   typedef struct {
      logic [127:0] st;
      logic [127:0] key;
      logic         byp;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [127:0] s, k, held, exp;
      logic         b;
      int           lat;
      int           acc_cyc [$];
      logic [127:0] q [$];
      logic [127:0] cur_exp;
      logic         pend_acc, pend_out;
      int           sent, received, last_acc, min_gap, guard;

      rstn = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_bypass = 1'b0;
      in_state = '0; in_key = '0;
      step(); step();
      chk("reset_o_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_o_ready", {127'd0, out_ready_dut}, 128'd1);
      chk("reset_o_state", out_state, 128'd0);
      rstn = 1'b1;
      step();

      // ---------------------------------------------- vector table
      vecs[0] = '{{4{32'h8e4da1bc}}, 128'd0, 1'b0, {4{32'hdb135345}}};
      vecs[1] = '{128'h9fdc589d_4d7ebdf8_c6c6c6c6_d5d5d7d6, 128'd0, 1'b0,
                  128'hf20a225c_2d26314c_c6c6c6c6_d4d4d4d5};
      vecs[2] = '{128'd0, {4{32'h8e4da1bc}}, 1'b0, {4{32'hdb135345}}};
      vecs[3] = '{128'd0, {4{32'h8e4da1bc}}, 1'b1, {4{32'h8e4da1bc}}};
      s = rand128(); k = rand128();
      vecs[4] = '{s, k, 1'b0, model(s, k, 1'b0)};
      s = rand128(); k = rand128();
      vecs[5] = '{s, k, 1'b1, model(s, k, 1'b1)};

      for (int i = 0; i < 6; i++) begin
         start_block(vecs[i].st, vecs[i].key, vecs[i].byp, lat);
         chk($sformatf("vec%0d_state", i), out_state, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
         accept_out();
      end

      // ---------------------------------------------- backpressure
      s = rand128(); k = rand128(); exp = model(s, k, 1'b0);
      start_block(s, k, 1'b0, lat);
      held = out_state;
      chk("bp_first", held, exp);
      for (int i = 0; i < 10; i++) begin
         in_state = rand128(); in_key = rand128(); in_valid = $urandom_range(0, 1);
         step();
         chk("bp_valid", {127'd0, out_valid}, 128'd1);
         chk("bp_ready", {127'd0, out_ready_dut}, 128'd0);
         chk("bp_state", out_state, exp);
      end
      in_valid = 1'b0;
      accept_out();
      chk("idle_holds_result", out_state, exp);

      // ---------------------------------------------- reset mid-BUSY
      in_state = rand128(); in_key = rand128(); in_bypass = 1'b0; in_valid = 1'b1;
      step();                       // accept edge
      in_valid = 1'b0;
      step();                       // column 0 done, col_cnt = 1
      step();                       // column 1 done, col_cnt = 2
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("rst_mid_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_mid_ready", {127'd0, out_ready_dut}, 128'd1);
      chk("rst_mid_state", out_state, 128'd0);
      s = rand128(); k = rand128();
      start_block(s, k, 1'b0, lat);
      chk("post_rst_state", out_state, model(s, k, 1'b0));
      chk("post_rst_latency", 128'(lat), 128'd4);
      accept_out();

      // ---------------------------------- throughput, i_Valid held high
      in_state = rand128(); in_key = rand128(); in_valid = 1'b1; in_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_ready_dut) acc_cyc.push_back(cyc);
         step();
      end
      in_valid = 1'b0;
      repeat (8) step();
      in_ready = 1'b0;
      chk("tp_accepts", 128'(acc_cyc.size()), 128'd4);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("tp_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd6);

      // ---------------------------------- random back-to-back handshake
      sent = 0; received = 0; last_acc = -100; min_gap = 1000; guard = 0;
      pend_acc = 1'b0; pend_out = 1'b0; cur_exp = '0;
      while (received < 20 && guard < 3000) begin
         step();
         guard++;
         if (pend_acc) begin
            q.push_back(cur_exp);
            if (sent > 0 && (cyc - last_acc) < min_gap) min_gap = cyc - last_acc;
            last_acc = cyc;
            sent++;
            in_valid = 1'b0;
         end
         if (pend_out) received++;
         if (!in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
            s = rand128(); k = rand128(); b = ($urandom_range(0, 3) == 0);
            in_state = s; in_key = k; in_bypass = b; in_valid = 1'b1;
            cur_exp = model(s, k, b);
         end else if (!in_valid) begin
            in_state = rand128();
         end
         in_ready = ($urandom_range(0, 3) != 0);
         pend_acc = in_valid && out_ready_dut;
         pend_out = out_valid && in_ready;
         if (pend_out) begin
            if (q.size() == 0) begin
               chk("rnd_unexpected_output", out_state, 128'd0);
               if (out_state === 128'd0) begin
                  errors++;
                  $display("FAIL rnd_duplicate actual=extra_output required=none");
               end
            end else begin
               chk("rnd_state", out_state, q.pop_front());
            end
         end
      end
      in_valid = 1'b0; in_ready = 1'b0;
      chk("rnd_received", 128'(received), 128'd20);
      chk("rnd_sent", 128'(sent), 128'd20);
      chk("rnd_queue_empty", 128'(q.size()), 128'd0);
      checks++;
      if (min_gap < 6) begin
         errors++;
         $display("FAIL rnd_min_spacing actual=%0d required>=6", min_gap);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
